// File: rtl/clk_div_multi_pkg.sv
// Shared definitions for the multi-channel clock divider: output modes,
// minimum divisor and the channel-select width helper.
package clk_div_multi_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int DIV_MIN = 2;

  // A single channel still needs a one-bit select port.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active and one-deep pending settings,
// and registered clk_out/tick decoded from the next counter value.
module clk_div_chan
  import clk_div_multi_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LO  = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] cnt, div, pdiv;
  logic [DIV_W-1:0] cnt_n, div_n, div_cap;
  mode_e            mode, pmode, mode_n;
  logic             run, wrap, apply, hit_n, high_n;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    wrap    = en && run && (cnt == div - DIV_ONE);
    // Pending settings land at a period boundary, or at once when idle.
    apply   = pend && (wrap || !(en && run));
    div_n   = apply ? pdiv : div;
    mode_n  = apply ? pmode : mode;
    cnt_n   = '0;
    if (en && run && !wrap) cnt_n = cnt + DIV_ONE;
    hit_n   = (cnt_n == div_n - DIV_ONE);
    high_n  = (mode_n == MODE_PULSE) ? hit_n
                                     : (cnt_n < div_n - (div_n >> 1));
    div_cap = (cfg_div < DIV_LO) ? DIV_LO : cfg_div;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the pending slot is reset too, which drops any write
  // still waiting when reset hits.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt     <= '0;
      run     <= 1'b0;
      div     <= DIV_RST;
      mode    <= MODE_SQUARE;
      pend    <= 1'b0;
      pdiv    <= DIV_RST;
      pmode   <= MODE_SQUARE;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      run     <= en;
      cnt     <= cnt_n;
      div     <= div_n;
      mode    <= mode_n;
      clk_out <= en && high_n;
      tick    <= en && hit_n;
      // A write is only accepted while pend is clear, so it never races apply.
      if (wr) begin
        pend  <= 1'b1;
        pdiv  <= div_cap;
        pmode <= mode_e'(cfg_mode);
      end else if (apply) begin
        pend  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable dividers sharing one clock, with a single
// valid/ready configuration port steered by cfg_ch.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int DIV_W   = 16,
  parameter  int DEF_DIV = 2,
  localparam int CH_W    = ch_width(NCH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  logic [NCH-1:0] pend;

  // Out-of-range channels never match, so they read as ready and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic wr;
    assign wr = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .en       (en[g]),
      .wr       (wr),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .pend     (pend[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a per-cycle vector table for the main
// scenarios plus hand sequences for clamping, enable drop and async reset.
module tb_clk_div_multi;

  localparam int NCH   = 4;
  localparam int DIV_W = 16;
  localparam int HALF  = 5;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [NCH-1:0]   en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  en;
    logic        v;
    logic [1:0]  ch;
    logic [15:0] div;
    logic        mode;
    logic        rdy;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_tick;
  } vec_t;

  vec_t vecs[$];

  clk_div_multi #(
    .NCH     (NCH),
    .DIV_W   (DIV_W),
    .DEF_DIV (2)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #HALF clk_in = ~clk_in;

  function automatic vec_t mk(input logic [3:0] e, input logic v, input logic [1:0] ch,
                              input logic [15:0] d, input logic m, input logic r,
                              input logic [3:0] c, input logic [3:0] t);
    vec_t x;
    x.en = e; x.v = v; x.ch = ch; x.div = d; x.mode = m;
    x.rdy = r; x.exp_clk = c; x.exp_tick = t;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    rst_in    = 1'b1;
    en        = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_mode  = 1'b0;

    // en, valid, ch, div, mode | ready | clk_out, tick (after the edge)
    // ch0 default D=2 square
    vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 1, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 1, 4'b0000, 4'b0001));
    vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 1, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 1, 4'b0000, 4'b0001));
    // ch1 D=5 square, written while idle
    vecs.push_back(mk(4'b0000, 1, 1, 5, 0, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 0, 1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 0, 1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 0, 1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 0, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 0, 1, 4'b0000, 4'b0010));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 0, 1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 0, 1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 0, 1, 4'b0010, 4'b0000));
    // mid-period write D=4 at cnt=2; second write blocked; ch0 still writable
    vecs.push_back(mk(4'b0010, 1, 1, 4, 0, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0010, 1, 1, 7, 0, 0, 4'b0000, 4'b0010));
    vecs.push_back(mk(4'b0010, 1, 0, 2, 0, 1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 4'b0000, 4'b0010));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 4'b0000, 4'b0010));
    // ch2 D=3 pulse
    vecs.push_back(mk(4'b0000, 1, 2, 3, 1, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 0, 2, 0, 0, 0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 0, 2, 0, 0, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 0, 2, 0, 0, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 0, 2, 0, 0, 1, 4'b0100, 4'b0100));
    vecs.push_back(mk(4'b0100, 0, 2, 0, 0, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 0, 2, 0, 0, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 0, 2, 0, 0, 1, 4'b0100, 4'b0100));

    step();
    step();
    check("reset clk_out", clk_out, 0);
    check("reset tick", tick, 0);
    check("reset cfg_ready", cfg_ready, 1);
    rst_in = 1'b0;

    foreach (vecs[i]) begin
      en        = vecs[i].en;
      cfg_valid = vecs[i].v;
      cfg_ch    = vecs[i].ch;
      cfg_div   = vecs[i].div;
      cfg_mode  = vecs[i].mode;
      #1;
      check($sformatf("row%0d cfg_ready", i), cfg_ready, vecs[i].rdy);
      step();
      check($sformatf("row%0d clk_out", i), clk_out, vecs[i].exp_clk);
      check($sformatf("row%0d tick", i), tick, vecs[i].exp_tick);
    end
    cfg_valid = 1'b0;

    // Divisor 0 and 1 both clamp to 2 on ch3.
    for (int c = 0; c < 2; c++) begin
      en        = '0;
      cfg_valid = 1'b1;
      cfg_ch    = 2'd3;
      cfg_div   = DIV_W'(c);
      cfg_mode  = 1'b0;
      step();
      cfg_valid = 1'b0;
      step();
      en = 4'b1000;
      for (int k = 0; k < 4; k++) begin
        step();
        check($sformatf("clamp%0d clk_out c%0d", c, k), clk_out, (k % 2 == 0) ? 4'b1000 : 4'b0000);
        check($sformatf("clamp%0d tick c%0d", c, k), tick, (k % 2 == 1) ? 4'b1000 : 4'b0000);
      end
    end

    // Drop en mid-period on ch1 (D=4), then restart from cnt=0.
    en = 4'b0010;
    step();
    check("drop pre c0 clk_out", clk_out, 4'b0010);
    step();
    check("drop pre c1 clk_out", clk_out, 4'b0010);
    en = 4'b0000;
    step();
    check("drop clk_out", clk_out, 4'b0000);
    check("drop tick", tick, 4'b0000);
    en = 4'b0010;
    step();
    check("reen c0 clk_out", clk_out, 4'b0010);
    step();
    check("reen c1 clk_out", clk_out, 4'b0010);
    step();
    check("reen c2 clk_out", clk_out, 4'b0000);
    step();
    check("reen c3 clk_out", clk_out, 4'b0000);
    check("reen c3 tick", tick, 4'b0010);

    // Async reset mid-period with a write pending on ch1.
    step();
    check("prerst clk_out", clk_out, 4'b0010);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 16'd6;
    cfg_mode  = 1'b0;
    #1;
    check("prerst cfg_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("prerst pending clk_out", clk_out, 4'b0010);
    #2;
    rst_in = 1'b1;
    #2;
    check("async rst clk_out", clk_out, 4'b0000);
    check("async rst tick", tick, 4'b0000);
    check("async rst cfg_ready", cfg_ready, 1);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("postrst clk_out c%0d", k), clk_out, (k % 2 == 0) ? 4'b0010 : 4'b0000);
      check($sformatf("postrst tick c%0d", k), tick, (k % 2 == 1) ? 4'b0010 : 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised successor to the fixed single-output clock divider.
- Produces NCH independent divided outputs from one input clock.
- Each channel has a runtime-programmable divisor, an output mode (square or one-cycle pulse) and an enable.
- Sits next to the top-level clock input and feeds slow enables and blink/strobe logic elsewhere in the design; outputs are registered strobes in the clk_in domain, not new clock domains.

Parameters:
- NCH, 4, number of output channels (1..16).
- DIV_W, 16, divisor/counter width in bits.
- DEF_DIV, 2, divisor loaded into every channel at reset (2..2^DIV_W-1).

Ports:
- clk_in  in  1  sole clock; all logic is posedge clk_in.
- rst_in  in  1  reset, asynchronous, active-high.
- en  in  NCH  per-channel run enable.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
- cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NCH)); values >= NCH are ignored (accepted, no effect).
- cfg_div  in  DIV_W  new divisor D.
- cfg_mode  in  1  0 = square, 1 = pulse.
- clk_out  out  NCH  divided outputs.
- tick  out  NCH  one-cycle end-of-period strobe per channel.

Behaviour:
- Reset: the reset is asynchronous and active-high, and is the only clocking exception; there is one clock. While rst_in is high, per channel: cnt=0, run=0, div=DEF_DIV, mode=0, pend=0, clk_out=0, tick=0. cfg_ready=1 after reset. Asserting reset mid-operation discards pending writes and restores this state.
- Per-channel state:
  - cnt: DIV_W bits.
  - run: registered en.
  - div, mode: active settings.
  - pend, pdiv, pmode: one-deep pending configuration.
- Counting, each edge:
  - en=0: cnt<=0, clk_out<=0, tick<=0.
  - en=1, run=0: cnt<=0 (period start).
  - en=1, run=1: cnt<=(cnt==div-1) ? 0 : cnt+1. Unsigned arithmetic; no overflow, since cnt < div <= 2^DIV_W-1.
- Outputs are registered and decoded from next-state cnt (n), so they track cnt with zero skew and change one edge after en rises:
  - Square mode: clk_out <= en && (n < div - div/2). High for ceil(D/2) cycles, low for floor(D/2). Odd D gives duty (D+1)/(2D).
  - Pulse mode: clk_out <= en && (n == div-1).
  - In both modes: tick <= en && (n == div-1).
- Divisor rules: cfg_div of 0 or 1 is clamped to 2 on capture. The minimum period is 2 cycles.
- Config handshake:
  - cfg_ready = !pend[cfg_ch] (combinational from registers and cfg_ch).
  - On accept: pdiv, pmode and pend are set for that channel.
  - Only one outstanding write per channel; other channels remain writable.
- Glitch-free update:
  - Pending settings take effect at the edge where cnt wraps (cnt==div-1 with run&&en), so the next period uses the new values. pend clears on the same edge.
  - If the channel is not running (en=0 or run=0), pending settings apply on the next edge.
- Simultaneous events:
  - A write accepted in the same cycle as a wrap is not applied at that wrap; it applies at the following wrap.
  - A write arriving while en falls applies on the next edge.
- Channels are fully independent; there is no phase alignment between channels.

Decomposition:
- Shared header clk_div_defs.vh:
  - mode constants MODE_SQUARE=0, MODE_PULSE=1.
  - CH_W computation macro/function.
  - minimum divisor constant DIV_MIN=2.
- One natural sub-module, clk_div_chan, instantiated NCH times by generate:
  - contains cnt, run, active and pending config, output decode.
  - top level contains only cfg_ch decode, the cfg_ready mux and port wiring.

Test Plan:
- Reset release with en=4'b0001, default D=2, square, clk period 2 ns: clk_out[0] rises one edge after en is sampled high, then toggles every cycle (4 ns period). tick[0] is high on every second cycle. Other channels stay 0.
- Write ch1 D=5 square, then en[1]=1: clk_out[1] pattern is 1,1,1,0,0 repeating (10 ns period). tick[1] is high in the 5th cycle of each period.
- Write ch2 D=3 pulse: clk_out[2] equals tick[2], a single-cycle high every 3 cycles.
- While ch1 is running D=5, write D=4 mid-period (cnt=2): the current period completes as 5 cycles, the next is 1,1,0,0. A second write before the wrap sees cfg_ready=0 with cfg_ch=1, while cfg_ch=0 shows cfg_ready=1.
- Write cfg_div=0 and, separately, cfg_div=1: both behave as D=2. Drop en mid-period: clk_out and tick go 0 next edge. Re-enable: the period restarts at cnt=0 with clk_out high.
- Assert rst_in asynchronously mid-period with a write pending: all outputs are 0 immediately and the pending write is lost. After release, the channel runs at D=DEF_DIV.
